// File: rtl/qspi_psram_target.sv
// QSPI/QPI PSRAM target: a byte array served by the 0xEB quad read and 0x38 quad write commands.
// sck is oversampled on clk. ce_n high aborts any transaction on the same clk.
module qspi_psram_target #(
  parameter int AW       = 10,
  parameter int WAIT_CYC = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       qpi_mode
);
  localparam int CW = $clog2(WAIT_CYC + 9);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;

  state_t        state_q, state_d;
  logic          sck_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nib_q, nib_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    hi_q, hi_d;
  logic [3:0]    sio_o_q, sio_o_d;
  logic          sio_oe_q, sio_oe_d;
  logic          qpi_q, qpi_d;

  logic          mem_we;
  logic [7:0]    mem_wdat;
  logic [7:0]    mem_rdat;
  logic [7:0]    mem [2**AW];

  logic          rise, fall;
  logic [7:0]    cmd_next;
  logic          cmd_last, addr_last, wait_last;

  assign rise      = sck & ~sck_q;
  assign fall      = ~sck & sck_q;
  assign cmd_next  = qpi_q ? {cmd_q[3:0], sio_i} : {cmd_q[6:0], sio_i[0]};
  assign cmd_last  = qpi_q ? (cnt_q == CW'(1)) : (cnt_q == CW'(7));
  assign addr_last = (cnt_q == CW'(5));
  assign wait_last = (cnt_q == CW'(WAIT_CYC - 1));
  assign mem_rdat  = mem[addr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sck_q    <= 1'b0;
      cnt_q    <= '0;
      nib_q    <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      hi_q     <= '0;
      sio_o_q  <= '0;
      sio_oe_q <= 1'b0;
      qpi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck;
      cnt_q    <= cnt_d;
      nib_q    <= nib_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
      sio_o_q  <= sio_o_d;
      sio_oe_q <= sio_oe_d;
      qpi_q    <= qpi_d;
    end
  end

  // Array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdat;
  end

  always_comb begin
    state_d = state_q;
    if (ce_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (rise && cmd_last) begin
            case (cmd_next)
              8'hEB, 8'h38: state_d = ADDR;
              default:      state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (rise && addr_last) begin
            if (cmd_q == 8'h38)     state_d = WDATA;
            else if (WAIT_CYC == 0) state_d = RDATA;
            else                    state_d = WAIT;
          end
        end
        WAIT:    if (rise && wait_last) state_d = RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    nib_d    = nib_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    sio_o_d  = sio_o_q;
    sio_oe_d = sio_oe_q;
    qpi_d    = qpi_q;
    mem_we   = 1'b0;
    mem_wdat = {hi_q, sio_i};
    if (ce_n) begin
      cnt_d    = '0;
      nib_d    = 1'b0;
      sio_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = '0;
          nib_d    = 1'b0;
          sio_oe_d = 1'b0;
        end
        CMD: begin
          if (rise) begin
            cmd_d = cmd_next;
            cnt_d = cnt_q + CW'(1);
            if (cmd_last) begin
              cnt_d = '0;
              if (cmd_next == 8'h35)      qpi_d = 1'b1;
              else if (cmd_next == 8'hF5) qpi_d = 1'b0;
            end
          end
        end
        ADDR: begin
          // Shifting through an AW-bit register keeps only the low address bits.
          if (rise) begin
            addr_d = AW'({addr_q, sio_i});
            cnt_d  = addr_last ? '0 : cnt_q + CW'(1);
          end
        end
        WAIT: begin
          if (rise) cnt_d = wait_last ? '0 : cnt_q + CW'(1);
        end
        RDATA: begin
          if (fall) begin
            sio_oe_d = 1'b1;
            sio_o_d  = nib_q ? mem_rdat[3:0] : mem_rdat[7:4];
            nib_d    = ~nib_q;
            if (nib_q) addr_d = addr_q + AW'(1);
          end
        end
        WDATA: begin
          if (rise) begin
            nib_d = ~nib_q;
            if (!nib_q) begin
              hi_d = sio_i;
            end else begin
              mem_we = 1'b1;
              addr_d = addr_q + AW'(1);
            end
          end
        end
        default: sio_oe_d = 1'b0;
      endcase
    end
  end

  assign sio_o    = sio_o_q;
  assign sio_oe   = sio_oe_q;
  assign qpi_mode = qpi_q;

endmodule

// File: tb/tb_qspi_psram_target.sv
// Bench for qspi_psram_target: initiator tasks plus a byte-array model feeding a read scoreboard.
module tb_qspi_psram_target;
  localparam int AW   = 10;
  localparam int WAIT = 6;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       sck    = 1'b0;
  logic       ce_n   = 1'b1;
  logic [3:0] sio_i  = 4'h0;
  logic [3:0] sio_o;
  logic       sio_oe;
  logic       qpi_mode;

  qspi_psram_target #(.AW(AW), .WAIT_CYC(WAIT)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n),
    .sio_i(sio_i), .sio_o(sio_o), .sio_oe(sio_oe), .qpi_mode(qpi_mode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       qpi_m = 1'b0;
  logic [7:0] mdl [1024];
  logic [3:0] exp_q [$];
  logic [3:0] obs_q [$];
  logic       obs_oe_q [$];
  logic       oe_pre;
  logic       oe_after;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sck period: fall, sample what the target drives, then rise with d on sio_i.
  task automatic nib_cycle(input logic [3:0] d, output logic [3:0] q, output logic oe);
    sck = 1'b0;
    tick(2);
    q     = sio_o;
    oe    = sio_oe;
    sio_i = d;
    sck   = 1'b1;
    tick(2);
  endtask

  task automatic start_txn();
    ce_n = 1'b0;
    tick(2);
  endtask

  task automatic end_txn();
    ce_n = 1'b1;
    tick(1);
    sck = 1'b0;
    tick(2);
  endtask

  task automatic send_cmd(input logic [7:0] c, output logic oe_any);
    logic [3:0] q;
    logic       oe;
    oe_any = 1'b0;
    if (qpi_m) begin
      nib_cycle(c[7:4], q, oe); oe_any |= oe;
      nib_cycle(c[3:0], q, oe); oe_any |= oe;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        nib_cycle({3'b000, c[i]}, q, oe);
        oe_any |= oe;
      end
    end
  endtask

  task automatic send_addr(input logic [23:0] a, output logic oe_any);
    logic [3:0] q;
    logic       oe;
    oe_any = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      nib_cycle(a[i*4 +: 4], q, oe);
      oe_any |= oe;
    end
  endtask

  task automatic do_write(input logic [23:0] a, input int n, input logic [15:0] data);
    logic [3:0] q;
    logic       oe;
    logic [7:0] b;
    start_txn();
    send_cmd(8'h38, oe);
    send_addr(a, oe);
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? data[15:8] : data[7:0];
      nib_cycle(b[7:4], q, oe);
      nib_cycle(b[3:0], q, oe);
      mdl[(a[9:0] + 10'(i)) & 10'h3FF] = b;
    end
    end_txn();
  endtask

  // Expected nibbles go to exp_q as the command is issued; observed ones to obs_q.
  task automatic do_read(input logic [23:0] a, input int n);
    logic [3:0] q;
    logic       oe;
    logic [7:0] b;
    logic       o1;
    for (int i = 0; i < n; i++) begin
      b = mdl[(a[9:0] + 10'(i)) & 10'h3FF];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    start_txn();
    send_cmd(8'hEB, o1);
    oe_pre = o1;
    send_addr(a, o1);
    oe_pre |= o1;
    for (int i = 0; i < WAIT; i++) begin
      nib_cycle(4'h0, q, oe);
      oe_pre |= oe;
    end
    for (int i = 0; i < 2 * n; i++) begin
      nib_cycle(4'h0, q, oe);
      obs_q.push_back(q);
      obs_oe_q.push_back(oe);
    end
    ce_n = 1'b1;
    tick(1);
    oe_after = sio_oe;
    sck = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++; if (sio_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", sio_oe); end
    total++; if (qpi_mode !== 1'b0) begin bad++; $display("FAIL reset_qpi got=%b exp=0", qpi_mode); end
    total++; if (sio_o !== 4'h0) begin bad++; $display("FAIL reset_sio_o got=%h exp=0", sio_o); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_qpi_enter();
    logic oe;
    logic [3:0] q;
    logic oe2;
    start_txn();
    send_cmd(8'h35, oe);
    total++; if (qpi_mode !== 1'b1) begin bad++; $display("FAIL qpi_on_last_rise got=%b exp=1", qpi_mode); end
    nib_cycle(4'hF, q, oe2);
    oe |= oe2;
    end_txn();
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL qpi_enter_oe got=%b exp=0", oe); end
    total++; if (qpi_mode !== 1'b1) begin bad++; $display("FAIL qpi_after_ce got=%b exp=1", qpi_mode); end
    qpi_m = 1'b1;
  endtask

  task automatic test_write_read();
    logic [3:0] e, o;
    logic       oe;
    do_write(24'h000010, 2, 16'hA53C);
    do_read(24'h000010, 2);
    total++; if (oe_pre !== 1'b0) begin bad++; $display("FAIL wr_rd_oe_pre got=%b exp=0", oe_pre); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oe = obs_oe_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wr_rd_nib got=%h exp=%h", o, e); end
      total++; if (oe !== 1'b1) begin bad++; $display("FAIL wr_rd_oe got=%b exp=1", oe); end
    end
    total++; if (oe_after !== 1'b0) begin bad++; $display("FAIL wr_rd_oe_ce got=%b exp=0", oe_after); end
  endtask

  task automatic test_wrap();
    logic [3:0] e, o;
    logic       oe;
    do_write(24'h0003FF, 2, 16'h1122);
    do_read(24'h0003FF, 1);
    do_read(24'h000000, 1);
    do_read(24'hFFF400, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oe = obs_oe_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL wrap_nib got=%h exp=%h", o, e); end
      total++; if (oe !== 1'b1) begin bad++; $display("FAIL wrap_oe got=%b exp=1", oe); end
    end
  endtask

  task automatic test_partial_unknown();
    logic [3:0] e, o, q;
    logic       oe, oe_any;
    do_write(24'h000020, 2, 16'h0055);
    start_txn();
    send_cmd(8'h38, oe);
    send_addr(24'h000020, oe);
    nib_cycle(4'h7, q, oe);
    nib_cycle(4'hE, q, oe);
    nib_cycle(4'h9, q, oe);
    end_txn();
    mdl[10'h020] = 8'h7E;
    do_read(24'h000020, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oe = obs_oe_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL partial_nib got=%h exp=%h", o, e); end
    end
    start_txn();
    send_cmd(8'h9F, oe_any);
    for (int i = 0; i < 14; i++) begin
      nib_cycle(4'(i), q, oe);
      oe_any |= oe;
    end
    ce_n = 1'b1;
    tick(1);
    oe_any |= sio_oe;
    sck = 1'b0;
    tick(2);
    total++; if (oe_any !== 1'b0) begin bad++; $display("FAIL unknown_cmd_oe got=%b exp=0", oe_any); end
    total++; if (qpi_mode !== 1'b1) begin bad++; $display("FAIL unknown_cmd_qpi got=%b exp=1", qpi_mode); end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] e, o, q;
    logic       oe;
    start_txn();
    send_cmd(8'hEB, oe);
    send_addr(24'h000010, oe);
    for (int i = 0; i < WAIT; i++) nib_cycle(4'h0, q, oe);
    nib_cycle(4'h0, q, oe);
    total++; if (oe !== 1'b1) begin bad++; $display("FAIL mid_read_oe got=%b exp=1", oe); end
    total++; if (q !== 4'hA) begin bad++; $display("FAIL mid_read_nib got=%h exp=a", q); end
    rst = 1'b1;
    #1;
    total++; if (sio_oe !== 1'b0) begin bad++; $display("FAIL rst_async_oe got=%b exp=0", sio_oe); end
    total++; if (qpi_mode !== 1'b0) begin bad++; $display("FAIL rst_async_qpi got=%b exp=0", qpi_mode); end
    tick(2);
    ce_n = 1'b1;
    sck  = 1'b0;
    rst  = 1'b0;
    tick(2);
    qpi_m = 1'b0;
    do_read(24'h000010, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oe = obs_oe_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL spi_read_nib got=%h exp=%h", o, e); end
      total++; if (oe !== 1'b1) begin bad++; $display("FAIL spi_read_oe got=%b exp=1", oe); end
    end
  endtask

  task automatic test_exit_qpi_coincident();
    logic [3:0] e, o, q;
    logic       oe;
    start_txn();
    send_cmd(8'h35, oe);
    end_txn();
    qpi_m = 1'b1;
    start_txn();
    send_cmd(8'hF5, oe);
    total++; if (qpi_mode !== 1'b0) begin bad++; $display("FAIL qpi_exit got=%b exp=0", qpi_mode); end
    end_txn();
    qpi_m = 1'b0;
    do_write(24'h000030, 1, 16'h6600);
    start_txn();
    send_cmd(8'h38, oe);
    send_addr(24'h000030, oe);
    nib_cycle(4'h9, q, oe);
    sck = 1'b0;
    tick(2);
    sio_i = 4'h1;
    sck   = 1'b1;
    ce_n  = 1'b1;
    tick(2);
    sck = 1'b0;
    tick(2);
    do_read(24'h000030, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oe = obs_oe_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL coincident_nib got=%h exp=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_qpi_enter();
    test_write_read();
    test_wrap();
    test_partial_unknown();
    test_reset_mid_read();
    test_exit_qpi_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
